// File: rtl/defines_package.sv
`default_nettype none
// ============================================================================
//  Module      : defines_package
//  Description : Shared geometry/colour types and triangle stream markers.
//  Revision    : 1.0 - initial release
// ============================================================================
package defines_package;

    localparam logic [31:0] FRAME_START = 32'd0;
    localparam logic [31:0] FRAME_END   = 32'd1;
    localparam int          TRI_WORDS   = 6;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Point3D;

    typedef struct packed {
        Point3D p;
        Point3D q;
        Point3D r;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

    typedef struct packed {
        Triangle3D geom;
        Color      col;
    } TriPacket;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } rx_state_t;

    // Builds a packet from the five buffered words plus the blue byte of w5.
    function automatic TriPacket unpack_words(input logic [4:0][31:0] w,
                                              input logic [7:0]       blue);
        TriPacket pk;
        pk.geom.p.x = w[0][15:0];
        pk.geom.p.y = w[0][31:16];
        pk.geom.p.z = w[1][15:0];
        pk.geom.q.x = w[1][31:16];
        pk.geom.q.y = w[2][15:0];
        pk.geom.q.z = w[2][31:16];
        pk.geom.r.x = w[3][15:0];
        pk.geom.r.y = w[3][31:16];
        pk.geom.r.z = w[4][15:0];
        pk.col.r    = w[4][23:16];
        pk.col.g    = w[4][31:24];
        pk.col.b    = blue;
        return pk;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tri_fifo
//  Description : Synchronous first-word-fall-through FIFO of TriPacket.
//  Revision    : 1.0 - initial release
// ============================================================================
module tri_fifo
    import defines_package::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   push_i,
    input  TriPacket               data_i,
    input  logic                   pop_i,
    output TriPacket               head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    TriPacket    mem_q [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == FULL_CNT);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tri_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tri_packet_rx
//  Description : Assembles six-word triangle packets framed by start/end
//                markers from a word stream and queues them for a consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tri_packet_rx
    import defines_package::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [31:0]        ahb_buffer,
    input  logic               ahb_data_available,
    output logic               ahb_user_read_buffer,
    output Triangle3D          triangle,
    output Color               color,
    output logic               tri_ready,
    input  logic               tri_read,
    output logic               frame_active,
    output logic               frame_done,
    output logic [COUNT_W-1:0] tri_count,
    output logic               protocol_error
);

    localparam int              WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int              CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam bit              WD_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
    localparam logic [2:0]      LAST_IDX = 3'(TRI_WORDS - 1);

    rx_state_t          state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [WD_W-1:0]    wdog_q, wdog_d, wdog_inc;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               perr_q, perr_d;
    logic               fdone_q, fdone_d;
    logic [4:0][31:0]   words_q;

    logic               accept;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    TriPacket           fifo_head;
    TriPacket           assembled;

    assign accept               = n_rst & ahb_data_available & ~fifo_full;
    assign ahb_user_read_buffer = accept;
    assign wdog_inc             = wdog_q + 1'b1;
    assign assembled            = unpack_words(words_q, ahb_buffer[7:0]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        cnt_d   = cnt_q;
        perr_d  = 1'b0;
        fdone_d = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ahb_buffer == FRAME_START) begin
                        state_d = ST_FRAME;
                        idx_d   = '0;
                        wdog_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        perr_d  = 1'b1;
                    end
                end
            end
            ST_FRAME: begin
                if (accept) begin
                    wdog_d = '0;
                    if (idx_q == '0 && ahb_buffer == FRAME_START) begin
                        perr_d = 1'b1;
                        cnt_d  = '0;
                    end else if (idx_q == '0 && ahb_buffer == FRAME_END) begin
                        state_d = ST_IDLE;
                        fdone_d = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        push  = 1'b1;
                        idx_d = '0;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (WD_EN && idx_q != '0) begin
                    // Stalled mid-packet: drop the partial packet once the limit is hit.
                    if (wdog_inc == WD_LIMIT) begin
                        wdog_d = '0;
                        idx_d  = '0;
                        perr_d = 1'b1;
                    end else begin
                        wdog_d = wdog_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wdog_q  <= '0;
            cnt_q   <= '0;
            perr_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
            fdone_q <= fdone_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && state_q == ST_FRAME && idx_q != LAST_IDX) begin
            words_q[idx_q] <= ahb_buffer;
        end
    end

    tri_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .push_i  (push),
        .data_i  (assembled),
        .pop_i   (tri_read),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_fifo_count: assert property (@(posedge clk) disable iff (!n_rst)
        (fifo_count <= CNT_W'(FIFO_DEPTH)) && (fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH))));

    assign triangle       = fifo_head.geom;
    assign color          = fifo_head.col;
    assign tri_ready      = ~fifo_empty;
    assign frame_active   = (state_q == ST_FRAME);
    assign frame_done     = fdone_q;
    assign protocol_error = perr_q;
    assign tri_count      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tri_packet_rx
//  Description : Self-checking bench for tri_packet_rx (vectors, corner
//                sequences and a randomized stream against a queue model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_packet_rx;
    import defines_package::*;

    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    typedef logic [5:0][31:0] words_t;
    typedef struct {
        words_t   w;
        TriPacket exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [31:0]   ahb_buffer = '0;
    logic          ahb_data_available = 1'b0;
    logic          ahb_user_read_buffer;
    Triangle3D     triangle;
    Color          color;
    logic          tri_ready;
    logic          tri_read = 1'b0;
    logic          frame_active;
    logic          frame_done;
    logic [CW-1:0] tri_count;
    logic          protocol_error;
    TriPacket      head_act;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;
    assign head_act = {triangle, color};

    tri_packet_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO),
        .COUNT_W        (CW)
    ) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .ahb_buffer           (ahb_buffer),
        .ahb_data_available   (ahb_data_available),
        .ahb_user_read_buffer (ahb_user_read_buffer),
        .triangle             (triangle),
        .color                (color),
        .tri_ready            (tri_ready),
        .tri_read             (tri_read),
        .frame_active         (frame_active),
        .frame_done           (frame_done),
        .tri_count            (tri_count),
        .protocol_error       (protocol_error)
    );

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Offers one word and returns just after the edge that consumes it.
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        ahb_buffer         = w;
        ahb_data_available = 1'b1;
        #1;
        while (!ahb_user_read_buffer && n < 100) begin
            tick();
            n++;
        end
        if (!ahb_user_read_buffer) begin
            n_vec++;
            n_err++;
            $display("FAIL send_word_timeout: got no ack expected ack for word %0h", w);
            ahb_data_available = 1'b0;
        end else begin
            tick();
            ahb_data_available = 1'b0;
        end
    endtask

    function automatic words_t enc(input TriPacket pk, input logic [23:0] junk);
        words_t w;
        w[0] = {pk.geom.p.y, pk.geom.p.x};
        w[1] = {pk.geom.q.x, pk.geom.p.z};
        w[2] = {pk.geom.q.z, pk.geom.q.y};
        w[3] = {pk.geom.r.y, pk.geom.r.x};
        w[4] = {pk.col.g, pk.col.r, pk.geom.r.z};
        w[5] = {junk, pk.col.b};
        return w;
    endfunction

    function automatic TriPacket dec(input words_t w);
        TriPacket pk;
        pk.geom.p = '{x: w[0][15:0],  y: w[0][31:16], z: w[1][15:0]};
        pk.geom.q = '{x: w[1][31:16], y: w[2][15:0],  z: w[2][31:16]};
        pk.geom.r = '{x: w[3][15:0],  y: w[3][31:16], z: w[4][15:0]};
        pk.col    = '{r: w[4][23:16], g: w[4][31:24], b: w[5][7:0]};
        return pk;
    endfunction

    function automatic TriPacket rnd_pkt();
        TriPacket pk;
        pk.geom.p.x = 16'($urandom_range(2, 65535));
        pk.geom.p.y = 16'($urandom);
        pk.geom.p.z = 16'($urandom);
        pk.geom.q   = '{x: 16'($urandom), y: 16'($urandom), z: 16'($urandom)};
        pk.geom.r   = '{x: 16'($urandom), y: 16'($urandom), z: 16'($urandom)};
        pk.col      = '{r: 8'($urandom), g: 8'($urandom), b: 8'($urandom)};
        return pk;
    endfunction

    task automatic send_pkt(input TriPacket pk);
        words_t w;
        w = enc(pk, 24'($urandom));
        for (int i = 0; i < 6; i++) send_word(w[i]);
    endtask

    task automatic pop_check(input string nm, input TriPacket e);
        chkb({nm, "_ready"}, tri_ready, 1'b1);
        chkw(nm, 192'(head_act), 192'(e));
        tri_read = 1'b1;
        tick();
        tri_read = 1'b0;
    endtask

    // ---------------- randomized stream against a queue model ----------------
    logic [31:0] gen[$];

    task automatic refill();
        int     r;
        int     n;
        words_t w;
        r = $urandom_range(0, 19);
        w = enc(rnd_pkt(), 24'($urandom));
        case (r)
            0: gen.push_back($urandom);
            1: begin
                n = $urandom_range(1, 5);
                for (int i = 0; i < n; i++) gen.push_back(w[i]);
            end
            2: gen.push_back(FRAME_END);
            3: gen.push_back(FRAME_START);
            default: for (int i = 0; i < 6; i++) gen.push_back(w[i]);
        endcase
    endtask

    task automatic run_random(input int cycles);
        TriPacket    exp_q[$];
        logic [31:0] pw[$];
        words_t      tmp;
        logic [31:0] w;
        bit          in_frame;
        bit          exp_pe;
        bit          exp_fd;
        bit          pe_n;
        bit          fd_n;
        bit          exp_ack;
        int          idle;
        int          cnt;
        int          gap;
        in_frame = 0; exp_pe = 0; exp_fd = 0; idle = 0; cnt = 0; gap = 0;
        for (int c = 0; c < cycles; c++) begin
            while (gen.size() < 8) refill();
            if (gap > 0) begin
                gap--;
                ahb_data_available = 1'b0;
            end else begin
                if ($urandom_range(0, 49) == 0) gap = $urandom_range(5, 12);
                ahb_data_available = ($urandom_range(0, 9) < 7);
            end
            ahb_buffer = ahb_data_available ? gen[0] : $urandom;
            tri_read   = (((c / 300) % 2) == 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 9) == 0);
            #1;
            exp_ack = ahb_data_available && (exp_q.size() < DEPTH);
            chkb("rnd_ack", ahb_user_read_buffer, exp_ack);
            chkb("rnd_ready", tri_ready, exp_q.size() > 0);
            chkb("rnd_frame_active", frame_active, in_frame);
            chkb("rnd_protocol_error", protocol_error, exp_pe);
            chkb("rnd_frame_done", frame_done, exp_fd);
            chkw("rnd_tri_count", 192'(tri_count), 192'(cnt));
            if (exp_q.size() > 0) chkw("rnd_head", 192'(head_act), 192'(exp_q[0]));

            pe_n = 0;
            fd_n = 0;
            if (tri_read && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_ack) begin
                w    = gen.pop_front();
                idle = 0;
                if (!in_frame) begin
                    if (w == FRAME_START) begin
                        in_frame = 1;
                        cnt      = 0;
                    end else begin
                        pe_n = 1;
                    end
                end else if (pw.size() == 0 && w == FRAME_START) begin
                    pe_n = 1;
                    cnt  = 0;
                end else if (pw.size() == 0 && w == FRAME_END) begin
                    in_frame = 0;
                    fd_n     = 1;
                end else begin
                    pw.push_back(w);
                    if (pw.size() == 6) begin
                        for (int i = 0; i < 6; i++) tmp[i] = pw[i];
                        exp_q.push_back(dec(tmp));
                        cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
                        pw.delete();
                    end
                end
            end else if (in_frame && pw.size() > 0) begin
                idle++;
                if (idle == TO) begin
                    pw.delete();
                    idle = 0;
                    pe_n = 1;
                end
            end
            exp_pe = pe_n;
            exp_fd = fd_n;
            tick();
        end
        ahb_data_available = 1'b0;
        tri_read           = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    vec_t     tv [3];
    TriPacket pk [5];
    words_t   ww;

    initial begin
        // Words listed w5 first, w0 last; expectations as {p.xyz, q.xyz, r.xyz, col.rgb}.
        tv[0].w   = {32'h00000000, 32'h00FF001E, 32'h01DF0230, 32'h001E01DF, 32'h00500032, 32'h01AE0140};
        tv[0].exp = {16'd320, 16'd430, 16'd50, 16'd80, 16'd479, 16'd30, 16'd560, 16'd479, 16'd30,
                     8'd255, 8'd0, 8'd0};
        tv[1].w   = {32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tv[1].exp = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                     8'hFF, 8'hFF, 8'h78};
        tv[2].w   = {32'hFFFFFF01, 32'h5AA50001, 32'h80007FFF, 32'h00000000, 32'h00000001, 32'h00000002};
        tv[2].exp = {16'h0002, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0001,
                     8'hA5, 8'h5A, 8'h01};

        // Reset: ack must stay low even with data offered.
        n_rst = 1'b0;
        ahb_data_available = 1'b1;
        ahb_buffer = FRAME_START;
        tick(); tick();
        chkb("rst_ack", ahb_user_read_buffer, 1'b0);
        chkb("rst_ready", tri_ready, 1'b0);
        chkb("rst_frame_active", frame_active, 1'b0);
        chkb("rst_frame_done", frame_done, 1'b0);
        chkb("rst_protocol_error", protocol_error, 1'b0);
        chkw("rst_tri_count", 192'(tri_count), 192'(0));
        ahb_data_available = 1'b0;
        n_rst = 1'b1;
        tick();

        // Table vectors, one frame per packet.
        for (int i = 0; i < 3; i++) begin
            chkw("vec_count_held", 192'(tri_count), 192'((i == 0) ? 0 : 1));
            send_word(FRAME_START);
            chkb("vec_frame_active", frame_active, 1'b1);
            chkw("vec_count_cleared", 192'(tri_count), 192'(0));
            for (int k = 0; k < 6; k++) send_word(tv[i].w[k]);
            send_word(FRAME_END);
            chkb("vec_frame_done", frame_done, 1'b1);
            chkb("vec_frame_ended", frame_active, 1'b0);
            tick();
            chkb("vec_frame_done_pulse", frame_done, 1'b0);
            chkw("vec_tri_count", 192'(tri_count), 192'(1));
            pop_check("vec_fields", tv[i].exp);
            chkb("vec_empty_after_pop", tri_ready, 1'b0);
        end

        // Non-marker word in IDLE is acknowledged and dropped.
        send_word(32'h5);
        chkb("idle_drop_error", protocol_error, 1'b1);
        chkb("idle_drop_inactive", frame_active, 1'b0);
        tick();
        chkb("idle_drop_pulse", protocol_error, 1'b0);
        chkb("idle_drop_no_tri", tri_ready, 1'b0);

        // Watchdog: three words, then TO idle cycles.
        for (int i = 0; i < 5; i++) pk[i] = rnd_pkt();
        send_word(FRAME_START);
        ww = enc(pk[0], 24'h0);
        for (int k = 0; k < 3; k++) send_word(ww[k]);
        for (int k = 1; k < TO; k++) begin
            tick();
            chkb("wd_early", protocol_error, 1'b0);
        end
        tick();
        chkb("wd_error", protocol_error, 1'b1);
        tick();
        chkb("wd_pulse", protocol_error, 1'b0);
        chkb("wd_still_frame", frame_active, 1'b1);
        send_pkt(pk[1]);
        pop_check("wd_next_tri", pk[1]);

        // Restart at a packet boundary after two triangles.
        send_pkt(pk[2]);
        send_pkt(pk[3]);
        chkw("restart_pre_count", 192'(tri_count), 192'(3));
        send_word(FRAME_START);
        chkb("restart_error", protocol_error, 1'b1);
        chkw("restart_count", 192'(tri_count), 192'(0));
        chkb("restart_frame", frame_active, 1'b1);
        pop_check("restart_fifo0", pk[2]);
        pop_check("restart_fifo1", pk[3]);
        chkb("restart_fifo_empty", tri_ready, 1'b0);
        send_word(FRAME_END);
        tick();

        // Backpressure: five packets into a four-deep FIFO with no reads.
        for (int i = 0; i < 5; i++) pk[i] = rnd_pkt();
        send_word(FRAME_START);
        for (int i = 0; i < 4; i++) send_pkt(pk[i]);
        ww = enc(pk[4], 24'hABCDEF);
        ahb_buffer = ww[0];
        ahb_data_available = 1'b1;
        #1;
        chkb("full_ack_low0", ahb_user_read_buffer, 1'b0);
        tick();
        chkb("full_ack_low1", ahb_user_read_buffer, 1'b0);
        tick();
        chkb("full_ack_low2", ahb_user_read_buffer, 1'b0);
        chkw("full_head", 192'(head_act), 192'(pk[0]));
        tri_read = 1'b1;
        #1;
        chkb("full_no_bypass", ahb_user_read_buffer, 1'b0);
        tick();
        tri_read = 1'b0;
        #1;
        chkb("full_ack_resumes", ahb_user_read_buffer, 1'b1);
        for (int k = 0; k < 6; k++) send_word(ww[k]);
        chkw("full_count", 192'(tri_count), 192'(5));
        for (int i = 1; i < 5; i++) pop_check("full_order", pk[i]);
        chkb("full_drained", tri_ready, 1'b0);
        send_word(FRAME_END);
        tick();

        // Reset mid-packet with one triangle queued.
        send_word(FRAME_START);
        send_pkt(rnd_pkt());
        ww = enc(rnd_pkt(), 24'h0);
        for (int k = 0; k < 4; k++) send_word(ww[k]);
        n_rst = 1'b0;
        ahb_buffer = ww[4];
        ahb_data_available = 1'b1;
        #1;
        chkb("mrst_ack", ahb_user_read_buffer, 1'b0);
        tick();
        chkb("mrst_ready", tri_ready, 1'b0);
        chkb("mrst_frame_active", frame_active, 1'b0);
        chkb("mrst_frame_done", frame_done, 1'b0);
        chkb("mrst_protocol_error", protocol_error, 1'b0);
        chkw("mrst_tri_count", 192'(tri_count), 192'(0));
        chkb("mrst_ack_held", ahb_user_read_buffer, 1'b0);
        n_rst = 1'b1;
        ahb_data_available = 1'b0;
        tick();
        send_word(ww[4]);
        chkb("mrst_partial_gone", protocol_error, 1'b1);
        chkb("mrst_idle", frame_active, 1'b0);

        // Clean start for the randomized phase.
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        run_random(4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/tri_packet_rx.md
TRI_PACKET_RX -- requirements
Module: tri_packet_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, assembled-triangle FIFO depth; power of two, >=2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle cycles allowed mid-packet; 0 disables the watchdog.
REQ-003 SHALL have parameter COUNT_W, default 16, width of tri_count.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port n_rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port ahb_buffer  in  32  incoming word.
REQ-007 SHALL have port ahb_data_available  in  1  word valid.
REQ-008 SHALL have port ahb_user_read_buffer  out  1  word consumed this cycle (combinational acknowledge).
REQ-009 SHALL have port triangle  out  Triangle3D  FIFO head triangle.
REQ-010 SHALL have port color  out  Color  FIFO head color.
REQ-011 SHALL have port tri_ready  out  1  FIFO non-empty.
REQ-012 SHALL have port tri_read  in  1  consumer pops head.
REQ-013 SHALL have port frame_active  out  1  between accepted start and end markers.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse after end marker.
REQ-015 SHALL have port tri_count  out  COUNT_W  triangles pushed in current/last frame.
REQ-016 SHALL have port protocol_error  out  1  one-cycle error pulse.

Function
REQ-017 SHALL define accept = ahb_data_available & ~fifo_full; ahb_user_read_buffer = accept; word consumed at the rising edge where accept=1.
REQ-018 SHALL implement FSM IDLE -> FRAME on consumed FRAME_START (32'd0); any other word consumed in IDLE is dropped with protocol_error.
REQ-019 SHALL, in FRAME, track word index 0..5; at index 0 FRAME_END (32'd1) -> IDLE, frame_done pulse next cycle; FIFO contents retained.
REQ-020 SHALL, at index 0 in FRAME, treat FRAME_START as restart: protocol_error, tri_count cleared, stay in FRAME, FIFO untouched.
REQ-021 SHALL decode words only at packet boundaries as markers; packed vertex p=(x=1,y=0) is therefore reserved.
REQ-022 SHALL unpack: w0 p.x[15:0],p.y[31:16]; w1 p.z,q.x; w2 q.y,q.z; w3 r.x,r.y; w4 r.z[15:0],col.r[23:16],col.g[31:24]; w5 col.b[7:0], upper bits ignored.
REQ-023 SHALL push {triangle,color} into FIFO on the edge consuming w5, index returns to 0, tri_count increments (saturating at all-ones).
REQ-024 SHALL present FIFO head first-word-fall-through; tri_ready = ~empty; pop on edge with tri_read & tri_ready; tri_read while empty ignored.
REQ-025 SHALL not bypass: when full, accept=0 even if tri_read is high that cycle; simultaneous push/pop when not full keeps occupancy constant.
REQ-026 SHALL run watchdog only while index!=0: counter increments each cycle without consumed word, clears on consumption; reaching TIMEOUT_CYCLES discards partial packet, index=0, protocol_error pulse, stays in FRAME.
REQ-027 SHALL register frame_done and protocol_error; both never high more than one cycle per event.
REQ-028 SHALL keep tri_count stable from FRAME_END until next FRAME_START, which clears it.

Reset
REQ-029 SHALL, on n_rst=0 at a rising edge, enter IDLE, index 0, watchdog 0, FIFO empty, tri_count 0, frame_active/frame_done/protocol_error/tri_ready 0.
REQ-030 SHALL discard any partial packet and FIFO contents when reset occurs mid-frame; ahb_user_read_buffer is 0 while n_rst=0.
REQ-031 SHALL drive triangle/color as don't-care while tri_ready=0.

Structure
REQ-032 SHALL place FRAME_START, FRAME_END, TRI_WORDS=6 and typedef TriPacket {Triangle3D, Color} in defines_package; reuse existing Point3D/Triangle3D/Color.
REQ-033 SHALL instantiate one sub-module tri_fifo (parametrised synchronous FWFT FIFO of TriPacket, full/empty/count outputs).

Verification
REQ-034 SHALL test: reset, 0, six words for p=(320,430,50),q=(80,479,30),r=(560,479,30),col=(255,0,0), 1 -> one pop shows exact fields, tri_count=1, frame_done one cycle.
REQ-035 SHALL test: FIFO_DEPTH=4, tri_read=0, five triangles streamed -> ack low from fifth packet's w0 until one pop, then resumes; all five delivered in order.
REQ-036 SHALL test: word 32'h5 in IDLE -> acked, dropped, protocol_error pulse, frame_active stays 0.
REQ-037 SHALL test: TIMEOUT_CYCLES=8, three words then 8 idle cycles -> protocol_error, next six words form a valid triangle.
REQ-038 SHALL test: 0 mid-frame at index 0 after 2 triangles -> protocol_error, tri_count=0, FIFO still holds 2.
REQ-039 SHALL test: n_rst low after w3 of a packet -> all outputs at reset values, FIFO empty next cycle.
